timer_tick_servicer: RTL and testbench

- Avalon-MM master that sits directly in front of the 16-bit interval timer slave port and drives it.
- Programs the timer period, starts it in continuous mode with interrupts enabled, then services each timer irq by clearing the status register.
- Delivers a one-cycle tick pulse and a free-running 32-bit tick count to downstream logic.
- Includes a watchdog that flags a fault when the timer stops producing interrupts.

---
 rtl/timer_tick_servicer.sv | 71 +++++++
 tb/tb_timer_tick_servicer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/timer_tick_servicer.sv
// timer_tick_servicer: Avalon-MM master that programs and services an interval timer (in: clk, reset_n async low, enable, clear_count, tm_irq; out: tm_address/chipselect/write_n/writedata write bus, tick, tick_count, running, fault)
module timer_tick_servicer #(
  parameter logic [31:0] PERIOD      = 32'd49999,
  parameter logic [31:0] WDOG_CYCLES = 32'd100000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        clear_count,
  input  logic        tm_irq,
  output logic [2:0]  tm_address,
  output logic        tm_chipselect,
  output logic        tm_write_n,
  output logic [15:0] tm_writedata,
  output logic        tick,
  output logic [31:0] tick_count,
  output logic        running,
  output logic        fault
);
  typedef enum logic [2:0] {IDLE, WR_PL, WR_PH, WR_CTRL, WAIT_IRQ, CLR, STOP} state_t;
  state_t state, state_nx;
  logic [31:0] wdog;
  logic wdog_hit;
  assign wdog_hit = wdog == WDOG_CYCLES - 32'd1;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE:     state_nx = enable ? WR_PL : IDLE;
      WR_PL:    state_nx = WR_PH;
      WR_PH:    state_nx = WR_CTRL;
      WR_CTRL:  state_nx = WAIT_IRQ;
      WAIT_IRQ: state_nx = !enable ? STOP : tm_irq ? CLR : WAIT_IRQ;
      CLR:      state_nx = WAIT_IRQ;
      STOP:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end
  always_comb begin
    tm_chipselect = 1'b1;
    tm_address = 3'd0;
    tm_writedata = 16'd0;
    case (state)
      WR_PL:   begin tm_address = 3'd2; tm_writedata = PERIOD[15:0]; end
      WR_PH:   begin tm_address = 3'd3; tm_writedata = PERIOD[31:16]; end
      WR_CTRL: begin tm_address = 3'd1; tm_writedata = 16'h0007; end
      CLR:     tm_chipselect = 1'b1;
      STOP:    begin tm_address = 3'd1; tm_writedata = 16'h0008; end
      default: tm_chipselect = 1'b0;
    endcase
  end
  assign tm_write_n = !tm_chipselect;
  assign tick = state == CLR;
  assign running = state inside {WR_CTRL, WAIT_IRQ, CLR, STOP};
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wdog <= '0;
      fault <= 1'b0;
      tick_count <= '0;
    end else begin
      if (state == WR_CTRL || state == CLR) wdog <= '0;
      else if (state == WAIT_IRQ && !wdog_hit) wdog <= wdog + 32'd1;
      // cleared on the edge into WR_PL so a fresh start shows fault=0 immediately
      if (state == IDLE && enable) fault <= 1'b0;
      else if (state == WAIT_IRQ && enable && !tm_irq && wdog_hit) fault <= 1'b1;
      if (clear_count) tick_count <= '0;
      else if (tick) tick_count <= tick_count + 32'd1;
    end
endmodule

// File: tb/tb_timer_tick_servicer.sv
// tb_timer_tick_servicer: vector table, directed corner sequences and random run against a write-queue reference model
module tb_timer_tick_servicer;
  localparam int W = 16;
  logic clk = 1'b0, reset_n = 1'b0, enable = 1'b0, clear_count = 1'b0, tm_irq = 1'b0;
  logic [2:0] tm_address;
  logic tm_chipselect, tm_write_n;
  logic [15:0] tm_writedata;
  logic tick, running, fault;
  logic [31:0] tick_count;
  int vectors = 0, miscompares = 0;
  timer_tick_servicer #(.WDOG_CYCLES(32'd16)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clear_count(clear_count), .tm_irq(tm_irq),
    .tm_address(tm_address), .tm_chipselect(tm_chipselect), .tm_write_n(tm_write_n),
    .tm_writedata(tm_writedata), .tick(tick), .tick_count(tick_count), .running(running), .fault(fault)
  );
  always #5 clk = ~clk;
  typedef struct packed {logic [2:0] a; logic [15:0] d;} wr_t;
  localparam wr_t W_PL = '{3'd2, 16'hC34F};
  localparam wr_t W_PH = '{3'd3, 16'h0000};
  localparam wr_t W_CTRL = '{3'd1, 16'h0007};
  localparam wr_t W_CLR = '{3'd0, 16'h0000};
  localparam wr_t W_STOP = '{3'd1, 16'h0008};
  wr_t pend[$];
  logic armed, m_fault;
  logic [31:0] m_cnt;
  int wd;
  typedef struct {
    logic en, cc, irq, cs;
    logic [2:0] a;
    logic [15:0] d;
    logic tk, run;
    logic [31:0] cnt;
  } vec_t;
  vec_t tbl[17];
  function automatic vec_t mk(logic en, logic cc, logic irq, logic cs, logic [2:0] a, logic [15:0] d,
                              logic tk, logic run, logic [31:0] cnt);
    vec_t v;
    v.en = en; v.cc = cc; v.irq = irq; v.cs = cs; v.a = a; v.d = d; v.tk = tk; v.run = run; v.cnt = cnt;
    return v;
  endfunction
  function automatic logic [55:0] pk(logic cs, logic [2:0] a, logic [15:0] d, logic tk, logic run,
                                     logic flt, logic [31:0] cnt);
    return {cs, !cs, a, d, tk, run, flt, cnt};
  endfunction
  function automatic logic [55:0] dut_out();
    return {tm_chipselect, tm_write_n, tm_address, tm_writedata, tick, running, fault, tick_count};
  endfunction
  function automatic logic [55:0] model_out();
    wr_t f;
    logic busy;
    busy = pend.size() > 0;
    f = busy ? pend[0] : W_CLR;
    return pk(busy, f.a, f.d, busy && f.a == 3'd0, armed || (busy && f == W_CTRL), m_fault, m_cnt);
  endfunction
  task automatic chk(input string name, input logic [55:0] act, input logic [55:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic model_reset();
    pend.delete();
    armed = 1'b0; m_fault = 1'b0; m_cnt = '0; wd = 0;
  endtask
  // one clock edge of the reference: queued writes drain one per cycle, otherwise react to inputs
  task automatic model_edge(input logic en, input logic cc, input logic irq);
    if (pend.size() > 0) begin
      wr_t f;
      f = pend.pop_front();
      if (f == W_CTRL) begin armed = 1'b1; wd = 0; end
      else if (f == W_CLR) begin m_cnt = m_cnt + 32'd1; wd = 0; end
      else if (f == W_STOP) armed = 1'b0;
    end else if (armed) begin
      if (!en) pend.push_back(W_STOP);
      else if (irq) pend.push_back(W_CLR);
      else if (wd == W - 1) m_fault = 1'b1;
      else wd++;
    end else if (en) begin
      m_fault = 1'b0;
      pend.push_back(W_PL); pend.push_back(W_PH); pend.push_back(W_CTRL);
    end
    if (cc) m_cnt = '0;
  endtask
  task automatic step(input logic en, input logic cc, input logic irq, input string name);
    @(negedge clk);
    chk(name, dut_out(), model_out());
    enable = en; clear_count = cc; tm_irq = irq;
    @(posedge clk);
    model_edge(en, cc, irq);
  endtask
  task automatic do_reset();
    reset_n = 1'b0; enable = 1'b0; clear_count = 1'b0; tm_irq = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("reset", dut_out(), pk(1'b0, 3'd0, 16'd0, 1'b0, 1'b0, 1'b0, 32'd0));
    reset_n = 1'b1;
    model_reset();
  endtask
  initial begin
    logic en_r, irq_r, clr_now;
    int p;
    tbl[0]  = mk(1, 0, 0, 0, 3'd0, 16'h0000, 0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 1, 3'd2, 16'hC34F, 0, 0, 0);
    tbl[2]  = mk(1, 0, 0, 1, 3'd3, 16'h0000, 0, 0, 0);
    tbl[3]  = mk(1, 0, 0, 1, 3'd1, 16'h0007, 0, 1, 0);
    tbl[4]  = mk(1, 0, 1, 0, 3'd0, 16'h0000, 0, 1, 0);
    tbl[5]  = mk(1, 0, 0, 1, 3'd0, 16'h0000, 1, 1, 0);
    tbl[6]  = mk(1, 0, 1, 0, 3'd0, 16'h0000, 0, 1, 1);
    tbl[7]  = mk(1, 1, 0, 1, 3'd0, 16'h0000, 1, 1, 1);
    tbl[8]  = mk(0, 0, 1, 0, 3'd0, 16'h0000, 0, 1, 0);
    tbl[9]  = mk(1, 0, 0, 1, 3'd1, 16'h0008, 0, 1, 0);
    tbl[10] = mk(1, 0, 0, 0, 3'd0, 16'h0000, 0, 0, 0);
    tbl[11] = mk(0, 0, 0, 1, 3'd2, 16'hC34F, 0, 0, 0);
    tbl[12] = mk(0, 0, 0, 1, 3'd3, 16'h0000, 0, 0, 0);
    tbl[13] = mk(0, 0, 0, 1, 3'd1, 16'h0007, 0, 1, 0);
    tbl[14] = mk(0, 0, 1, 0, 3'd0, 16'h0000, 0, 1, 0);
    tbl[15] = mk(0, 0, 0, 1, 3'd1, 16'h0008, 0, 1, 0);
    tbl[16] = mk(0, 0, 0, 0, 3'd0, 16'h0000, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      chk($sformatf("vec%0d", i), dut_out(),
          pk(tbl[i].cs, tbl[i].a, tbl[i].d, tbl[i].tk, tbl[i].run, 1'b0, tbl[i].cnt));
      enable = tbl[i].en; clear_count = tbl[i].cc; tm_irq = tbl[i].irq;
      @(posedge clk);
      model_edge(tbl[i].en, tbl[i].cc, tbl[i].irq);
    end
    do_reset();
    for (int i = 0; i < 19; i++) step(1'b1, 1'b0, 1'b0, "wdog_run");
    #1 chk("wdog_not_yet", 56'(fault), 56'd0);
    step(1'b1, 1'b0, 1'b0, "wdog_run");
    #1 chk("wdog_set", 56'(fault), 56'd1);
    step(1'b0, 1'b0, 1'b0, "wdog_stop");
    step(1'b0, 1'b0, 1'b0, "wdog_stop");
    #1 chk("wdog_sticky_idle", 56'(fault), 56'd1);
    step(1'b1, 1'b0, 1'b0, "wdog_restart");
    #1 chk("wdog_clr_wrpl", {56'(fault), 56'(tm_address)}, {56'd0, 56'd2});
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, "init");
    #1 force dut.tick_count = 32'hFFFF_FFFF;
    #1 release dut.tick_count;
    m_cnt = 32'hFFFF_FFFF;
    step(1'b1, 1'b0, 1'b1, "wrap_irq");
    step(1'b1, 1'b0, 1'b0, "wrap_clr");
    #1 chk("wrap_zero", 56'(tick_count), 56'd0);
    step(1'b1, 1'b0, 1'b1, "cc_irq");
    step(1'b1, 1'b0, 1'b0, "cc_clr1");
    step(1'b1, 1'b0, 1'b1, "cc_irq");
    #1 chk("cc_tick", {56'(tick), 56'(tick_count)}, {56'd1, 56'd1});
    step(1'b1, 1'b1, 1'b0, "cc_clr2");
    #1 chk("cc_wins", 56'(tick_count), 56'd0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b1, "ten_irq");
      step(1'b1, 1'b0, 1'b0, "ten_clr");
    end
    #1 chk("ten_count", 56'(tick_count), 56'd10);
    step(1'b1, 1'b0, 1'b1, "arst_irq");
    #1 chk("arst_in_clr", 56'(tick), 56'd1);
    reset_n = 1'b0;
    #1 chk("arst_async", dut_out(), pk(1'b0, 3'd0, 16'd0, 1'b0, 1'b0, 1'b0, 32'd0));
    model_reset();
    @(posedge clk);
    #1 reset_n = 1'b1;
    step(1'b1, 1'b0, 1'b0, "arst_idle");
    #1 chk("arst_restart", 56'(tm_address), 56'd2);
    en_r = 1'b1; irq_r = 1'b0; p = 8;
    for (int i = 0; i < 2000; i++) begin
      if (i % 200 == 0) p = int'($urandom_range(2, 40));
      clr_now = pend.size() > 0 && pend[0] == W_CLR;
      if ($urandom_range(0, 19) == 0) en_r = !en_r;
      step(en_r, $urandom_range(0, 15) == 0, irq_r, "rand");
      irq_r = clr_now ? 1'b0 : (irq_r || $urandom_range(1, p) == 1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
